// File: rtl/common_enums_pkg.sv
// Shared enums and packet-type constants for the UART transmit path.
package common_enums;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } tx_sched_state_t;

    localparam logic [1:0] PKT_MOVE = 2'b00;
    localparam logic [1:0] PKT_SYNC = 2'b01;
    localparam logic [1:0] PKT_MODE = 2'b10;
    localparam logic [1:0] PKT_HB   = 2'b11;

    function automatic logic [1:0] pkt_type(input logic [15:0] pkt);
        return pkt[15:14];
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Fixed-priority requester 0 over a round-robin pool of requesters 1..NUM_REQ-1.
module rr_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W:0]   probe;

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        probe       = '0;
        if (valid[0]) begin
            grant[0]    = 1'b1;
            grant_valid = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ - 1; k++) begin
                probe = {1'b0, rr_ptr} + (IDX_W+1)'(k);
                if (probe >= (IDX_W+1)'(NUM_REQ))
                    probe = probe - (IDX_W+1)'(NUM_REQ - 1);
                if (!grant_valid && valid[probe[IDX_W-1:0]]) begin
                    grant[probe[IDX_W-1:0]] = 1'b1;
                    grant_idx               = probe[IDX_W-1:0];
                    grant_valid             = 1'b1;
                end
            end
        end
    end

    // Requester 0 (grant_idx == 0) never moves the pointer.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset)
            rr_ptr <= IDX_W'(1);
        else if (advance && grant_valid && grant_idx != '0)
            rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? IDX_W'(1) : grant_idx + IDX_W'(1);
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART TX core between packet producers: load, start, wait, gap, watchdog.
// Optional heartbeat packet source is built only when UART_TX_HEARTBEAT_EN is defined.
module uart_tx_scheduler
    import common_enums::*;
#(
    parameter int  NUM_REQ        = 4,
    parameter int  DATA_W         = 16,
    parameter int  GAP_CYCLES     = 16,
    parameter int  TIMEOUT_CYCLES = 100000,
    parameter int  HB_PERIOD      = 50000000,
    localparam int GID_W          = $clog2(NUM_REQ + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    input  logic                      tx_done,
    output logic [GID_W-1:0]          grant_id,
    output logic                      sched_busy,
    output logic                      timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 2);
    localparam tx_sched_state_t POST_TX = (GAP_CYCLES == 0) ? IDLE : GAP;

    if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYCLES < 0 || TIMEOUT_CYCLES < 2 || HB_PERIOD < 1)
    begin : g_bad_params
        $error("uart_tx_scheduler: parameter out of range");
    end

    tx_sched_state_t    state;
    logic [NUM_REQ-1:0] win_onehot;
    logic [IDX_W-1:0]   win_idx;
    logic               win_valid;
    logic               take_req;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [TMO_W-1:0]   tmo_next;
    logic [GAP_W-1:0]   gap_cnt;

    assign take_req = (state == IDLE) && win_valid;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk         (clk),
        .reset       (reset),
        .valid       (req_valid),
        .advance     (take_req),
        .grant       (win_onehot),
        .grant_idx   (win_idx),
        .grant_valid (win_valid)
    );

    assign req_ready  = (!reset && state == IDLE) ? win_onehot : '0;
    assign tx_start   = !reset && (state == START) && !tx_busy;
    assign sched_busy = (state != IDLE);
    assign tmo_next   = tmo_cnt + TMO_W'(1);

`ifdef UART_TX_HEARTBEAT_EN
    localparam int HB_W = $clog2(HB_PERIOD + 1);

    logic [HB_W-1:0] hb_cnt;
    logic            hb_pending;
    logic [13:0]     hb_seq;
    logic            take_hb;

    assign take_hb = (state == IDLE) && !win_valid && hb_pending;

    // A tick that coincides with a grant re-arms the pending flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            hb_cnt     <= '0;
            hb_pending <= 1'b0;
            hb_seq     <= '0;
        end else begin
            if (take_hb) begin
                hb_pending <= 1'b0;
                hb_seq     <= hb_seq + 14'd1;
            end
            if (hb_cnt == HB_W'(HB_PERIOD - 1)) begin
                hb_cnt     <= '0;
                hb_pending <= 1'b1;
            end else begin
                hb_cnt <= hb_cnt + HB_W'(1);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            tx_data     <= '0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
            tmo_cnt     <= '0;
            gap_cnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (win_valid) begin
                        tx_data  <= req_data[win_idx*DATA_W +: DATA_W];
                        grant_id <= GID_W'(win_idx);
                        state    <= START;
                    end
`ifdef UART_TX_HEARTBEAT_EN
                    else if (take_hb) begin
                        tx_data  <= DATA_W'({PKT_HB, hb_seq});
                        grant_id <= GID_W'(NUM_REQ);
                        state    <= START;
                    end
`endif
                end
                START: begin
                    if (!tx_busy) begin
                        tmo_cnt <= '0;
                        state   <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    // tx_done is tested first so it wins over a coincident expiry.
                    if (tx_done) begin
                        gap_cnt <= '0;
                        state   <= POST_TX;
                    end else if (tmo_next == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        gap_cnt     <= '0;
                        state       <= POST_TX;
                    end else begin
                        tmo_cnt <= tmo_next;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1))
                        state <= IDLE;
                    else
                        gap_cnt <= gap_cnt + GAP_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
